// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of NUM_PORTS registered CDB ports
// among NUM_REQ writeback hold buffers. Optional macro: CDB_ARB_PERF_EN.
package cdb_arbiter_pkg;
  typedef struct packed {
    logic [5:0]  prd;
    logic [5:0]  rob_id;
    logic [31:0] value;
    logic        exc;
  } CDB_t;
endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int PAYLOAD_W = $bits(CDB_t),
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]  req_payload,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_PORTS-1:0]               bus_valid,
  output logic [NUM_PORTS-1:0][PAYLOAD_W-1:0] bus_payload,
  output logic [NUM_PORTS-1:0][SRC_W-1:0]    bus_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]           stall_cnt
`endif
);

  logic [NUM_REQ-1:0]                  hold_valid;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]   hold_data;
  logic [SRC_W-1:0]                    rr_ptr;
  logic [SRC_W-1:0]                    rr_next;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_PORTS-1:0]                port_vld;
  logic [NUM_PORTS-1:0][SRC_W-1:0]     port_sel;
  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0] port_data;

  // Scan from rr_ptr, hand the k-th valid entry to port k.
  always_comb begin
    int pos;
    int cnt;
    int last;
    grant     = '0;
    port_vld  = '0;
    port_sel  = '0;
    port_data = '0;
    pos       = 0;
    cnt       = 0;
    last      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = int'(rr_ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == pos && hold_valid[i] && cnt < NUM_PORTS) begin
          grant[i] = 1'b1;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == cnt) begin
              port_vld[p]  = 1'b1;
              port_sel[p]  = SRC_W'(i);
              port_data[p] = hold_data[i];
            end
          end
          last = i;
          cnt  = cnt + 1;
        end
      end
    end
    rr_next = rr_ptr;
    if (cnt > 0) begin
      rr_next = (last == NUM_REQ - 1) ? '0 : SRC_W'(last + 1);
    end
  end

  // A granted entry frees its slot in the same cycle.
  assign req_ready = {NUM_REQ{!flush}} & (~hold_valid | grant);

  // Hold buffers: accept beats grant-clear, flush drops everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      hold_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush) begin
          hold_valid[i] <= 1'b0;
        end else if (req_valid[i] && req_ready[i]) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= req_payload[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves past the last winner; frozen on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!flush) begin
      rr_ptr <= rr_next;
    end
  end

  // Registered broadcast ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_valid   <= '0;
      bus_payload <= '0;
      bus_src     <= '0;
    end else begin
      bus_valid <= flush ? '0 : port_vld;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_vld[p] && !flush) begin
          bus_payload[p] <= port_data[p];
          bus_src[p]     <= port_sel[p];
        end
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  // Saturating count of cycles an entry waits without a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hold_valid[i] && !grant[i] && stall_cnt[i] != 32'hFFFF_FFFF) begin
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
